// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Shares the single-port data RAM between the DLX data port (m0) and a second bus master (m1).
// Latency: read 3 cycles request-to-rvalid (timeout gives DEADBEEF+err at 2+TIMEOUT); write 2 cycles per access.
// Backpressure: requests are held until a one-cycle gnt; only one access is outstanding at a time.
module dmem_arbiter #(
    parameter int TIMEOUT     = 15,
    parameter int M0_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    output logic        m1_err,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_rdata_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [31:0] TMO_RDATA = 32'hDEAD_BEEF;

    state_t     state, state_nxt;
    logic       owner;
    logic       last;
    logic [7:0] cnt;

    logic       win;
    logic       take;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       rd_ok;
    logic       rd_tmo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win       = 1'b0;
        take      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        rd_ok     = 1'b0;
        rd_tmo    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, round-robin favours whichever master was not served last
                if (m0_req && m1_req) begin
                    win = (M0_PRIORITY != 0) ? 1'b0 : ~last;
                end else begin
                    win = m1_req;
                end
                if (m0_req || m1_req) begin
                    take      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_we) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_clr   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (ram_rdata_valid) begin
                    rd_ok     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt == TMO_LAST) begin
                        rd_tmo    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= 8'd0;
            ram_addr  <= 32'd0;
            ram_wdata <= 32'd0;
            ram_we    <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;

            // ram_we is only ever high for the single ISSUE cycle that follows a take
            if (take) begin
                ram_addr  <= win ? m1_addr  : m0_addr;
                ram_wdata <= win ? m1_wdata : m0_wdata;
                ram_we    <= win ? m1_we    : m0_we;
                owner     <= win;
                last      <= win;
            end else begin
                ram_we <= 1'b0;
            end

            if (cnt_clr) begin
                cnt <= 8'd0;
            end else if (cnt_inc) begin
                cnt <= cnt + 8'd1;
            end

            if (rd_ok || rd_tmo) begin
                if (owner) begin
                    m1_rdata  <= rd_ok ? ram_rdata : TMO_RDATA;
                    m1_rvalid <= 1'b1;
                    m1_err    <= rd_tmo;
                end else begin
                    m0_rdata  <= rd_ok ? ram_rdata : TMO_RDATA;
                    m0_rvalid <= 1'b1;
                    m0_err    <= rd_tmo;
                end
            end
        end
    end

    assign m0_gnt = (state == ISSUE) && !owner;
    assign m1_gnt = (state == ISSUE) &&  owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench: directed stimulus queues expected grants/read completions, negedge monitors compare.
module tb_dmem_arbiter;

    localparam int EV_GNT = 0;
    localparam int EV_RV  = 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] dat;
        logic        err;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT0: round-robin, TIMEOUT=4
    logic        m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, ram_rdata_valid;
    logic        rsp_en = 1, rsp_vld = 0, inj_vld = 0, fire0 = 0;
    logic [31:0] rsp_dat = 0, inj_dat = 0, a0 = 0;

    // DUT1: master-0 priority
    logic        p_m0_req = 0, p_m1_req = 0, p_m0_we = 0, p_m1_we = 0;
    logic [31:0] p_m0_addr = 0, p_m1_addr = 0, p_m0_wdata = 0, p_m1_wdata = 0;
    logic        p_m0_gnt, p_m1_gnt, p_m0_rvalid, p_m1_rvalid, p_m0_err, p_m1_err;
    logic [31:0] p_m0_rdata, p_m1_rdata, p_ram_addr, p_ram_wdata, p_ram_rdata;
    logic        p_ram_we, p_ram_rdata_valid;
    logic        p_rsp_vld = 0, fire1 = 0;
    logic [31:0] p_rsp_dat = 0, a1 = 0;

    assign ram_rdata_valid   = rsp_vld | inj_vld;
    assign ram_rdata         = inj_vld ? inj_dat : rsp_dat;
    assign p_ram_rdata_valid = p_rsp_vld;
    assign p_ram_rdata       = p_rsp_dat;

    dmem_arbiter #(.TIMEOUT(4), .M0_PRIORITY(0)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_rdata_valid(ram_rdata_valid)
    );

    dmem_arbiter #(.TIMEOUT(15), .M0_PRIORITY(1)) u_dut_pri (
        .clk(clk), .reset(reset),
        .m0_req(p_m0_req), .m0_we(p_m0_we), .m0_addr(p_m0_addr), .m0_wdata(p_m0_wdata),
        .m0_gnt(p_m0_gnt), .m0_rdata(p_m0_rdata), .m0_rvalid(p_m0_rvalid), .m0_err(p_m0_err),
        .m1_req(p_m1_req), .m1_we(p_m1_we), .m1_addr(p_m1_addr), .m1_wdata(p_m1_wdata),
        .m1_gnt(p_m1_gnt), .m1_rdata(p_m1_rdata), .m1_rvalid(p_m1_rvalid), .m1_err(p_m1_err),
        .ram_addr(p_ram_addr), .ram_we(p_ram_we), .ram_wdata(p_ram_wdata),
        .ram_rdata(p_ram_rdata), .ram_rdata_valid(p_ram_rdata_valid)
    );

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'h1234_5678 : ~a;
    endfunction

    // RAM responders: answer a read command one cycle after it is presented
    always @(posedge clk) begin
        fire0 = (m0_gnt | m1_gnt) & ~ram_we & rsp_en;
        a0    = ram_addr;
        #1;
        rsp_vld = fire0;
        rsp_dat = fire0 ? ram_val(a0) : 32'h0;
    end

    always @(posedge clk) begin
        fire1 = (p_m0_gnt | p_m1_gnt) & ~p_ram_we;
        a1    = p_ram_addr;
        #1;
        p_rsp_vld = fire1;
        p_rsp_dat = fire1 ? ram_val(a1) : 32'h0;
    end

    ev_t         q0[$];
    ev_t         q1[$];
    logic [31:0] mdl_rd[2][2];

    function automatic ev_t mk_gnt(int c, logic m, logic we, logic [31:0] a, logic [31:0] d);
        ev_t e;
        e.cyc = c; e.kind = EV_GNT; e.m = m; e.we = we; e.addr = a; e.dat = d; e.err = 1'b0;
        return e;
    endfunction

    function automatic ev_t mk_rv(int c, logic m, logic [31:0] d, logic err);
        ev_t e;
        e.cyc = c; e.kind = EV_RV; e.m = m; e.we = 1'b0; e.addr = 32'h0; e.dat = d; e.err = err;
        return e;
    endfunction

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input int d, input ev_t got);
        ev_t exp;
        logic empty;
        logic ok;
        checks++;
        empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            errors++;
            $display("FAIL dut%0d unexpected_event: got kind=%0d m=%0d addr=%h dat=%h, expected none (cycle %0d)",
                     d, got.kind, got.m, got.addr, got.dat, cyc);
            return;
        end
        if (d == 0) exp = q0.pop_front();
        else        exp = q1.pop_front();
        ok = (got.cyc == exp.cyc) && (got.kind == exp.kind) && (got.m == exp.m);
        if (exp.kind == EV_GNT)
            ok = ok && (got.we == exp.we) && (got.addr == exp.addr) && (!exp.we || got.dat == exp.dat);
        else
            ok = ok && (got.dat == exp.dat) && (got.err == exp.err);
        if (!ok) begin
            errors++;
            $display("FAIL dut%0d event: got cyc=%0d kind=%0d m=%0d we=%0d addr=%h dat=%h err=%0d, expected cyc=%0d kind=%0d m=%0d we=%0d addr=%h dat=%h err=%0d",
                     d, got.cyc, got.kind, got.m, got.we, got.addr, got.dat, got.err,
                     exp.cyc, exp.kind, exp.m, exp.we, exp.addr, exp.dat, exp.err);
        end
        if (exp.kind == EV_RV) mdl_rd[d][exp.m] = exp.dat;
    endtask

    task automatic observe(input int d, input logic rst, input logic g0, input logic g1,
                           input logic rv0, input logic rv1, input logic e0, input logic e1,
                           input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        ev_t got;
        if (rst) begin
            mdl_rd[d][0] = 32'h0;
            mdl_rd[d][1] = 32'h0;
        end
        if (g0 || g1) begin
            got = mk_gnt(cyc, g1, we, a, wd);
            pop_cmp(d, got);
        end
        if (rv0 || rv1) begin
            got = mk_rv(cyc, rv1, rv1 ? rd1 : rd0, rv1 ? e1 : e0);
            pop_cmp(d, got);
        end
        chk32($sformatf("dut%0d_gnt_onehot", d), 32'(g0 & g1), 32'h0);
        chk32($sformatf("dut%0d_we_outside_issue", d), 32'(we & ~(g0 | g1)), 32'h0);
        chk32($sformatf("dut%0d_err_without_rvalid", d), 32'((e0 & ~rv0) | (e1 & ~rv1)), 32'h0);
        chk32($sformatf("dut%0d_m0_rdata", d), rd0, mdl_rd[d][0]);
        chk32($sformatf("dut%0d_m1_rdata", d), rd1, mdl_rd[d][1]);
    endtask

    always @(negedge clk) begin
        observe(0, reset, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
                ram_we, ram_addr, ram_wdata, m0_rdata, m1_rdata);
        observe(1, reset, p_m0_gnt, p_m1_gnt, p_m0_rvalid, p_m1_rvalid, p_m0_err, p_m1_err,
                p_ram_we, p_ram_addr, p_ram_wdata, p_m0_rdata, p_m1_rdata);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk32({tag, "_m0_gnt"},    32'(m0_gnt),    32'h0);
        chk32({tag, "_m1_gnt"},    32'(m1_gnt),    32'h0);
        chk32({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'h0);
        chk32({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'h0);
        chk32({tag, "_m0_err"},    32'(m0_err),    32'h0);
        chk32({tag, "_m1_err"},    32'(m1_err),    32'h0);
        chk32({tag, "_m0_rdata"},  m0_rdata,       32'h0);
        chk32({tag, "_m1_rdata"},  m1_rdata,       32'h0);
        chk32({tag, "_ram_addr"},  ram_addr,       32'h0);
        chk32({tag, "_ram_we"},    32'(ram_we),    32'h0);
        chk32({tag, "_ram_wdata"}, ram_wdata,      32'h0);
    endtask

    initial begin
        int c0;
        mdl_rd[0][0] = 0; mdl_rd[0][1] = 0; mdl_rd[1][0] = 0; mdl_rd[1][1] = 0;

        tick(2);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(1);

        // single read by m0
        c0 = cyc;
        m0_addr = 32'h10; m0_we = 0; m0_req = 1;
        q0.push_back(mk_gnt(c0 + 1, 0, 0, 32'h10, 32'h0));
        q0.push_back(mk_rv(c0 + 3, 0, 32'h1234_5678, 0));
        tick(2); m0_req = 0;
        tick(3);
        chk32("read_m1_rdata_untouched", m1_rdata, 32'h0);

        // single write by m1
        c0 = cyc;
        m1_addr = 32'h20; m1_wdata = 32'hCAFE_F00D; m1_we = 1; m1_req = 1;
        q0.push_back(mk_gnt(c0 + 1, 1, 1, 32'h20, 32'hCAFE_F00D));
        tick(2); m1_req = 0; m1_we = 0;
        tick(1);
        chk32("write_addr_hold",  ram_addr,  32'h20);
        chk32("write_wdata_hold", ram_wdata, 32'hCAFE_F00D);

        // round-robin contention (last served was m1, so m0 first)
        c0 = cyc;
        m0_addr = 32'h100; m1_addr = 32'h200; m0_req = 1; m1_req = 1;
        q0.push_back(mk_gnt(c0 + 1,  0, 0, 32'h100, 0));
        q0.push_back(mk_rv (c0 + 3,  0, 32'hFFFF_FEFF, 0));
        q0.push_back(mk_gnt(c0 + 4,  1, 0, 32'h200, 0));
        q0.push_back(mk_rv (c0 + 6,  1, 32'hFFFF_FDFF, 0));
        q0.push_back(mk_gnt(c0 + 7,  0, 0, 32'h100, 0));
        q0.push_back(mk_rv (c0 + 9,  0, 32'hFFFF_FEFF, 0));
        q0.push_back(mk_gnt(c0 + 10, 1, 0, 32'h200, 0));
        q0.push_back(mk_rv (c0 + 12, 1, 32'hFFFF_FDFF, 0));
        tick(8); m0_req = 0;
        tick(3); m1_req = 0;
        tick(3);

        // priority contention on the second instance
        c0 = cyc;
        p_m0_addr = 32'h300; p_m1_addr = 32'h400; p_m0_req = 1; p_m1_req = 1;
        q1.push_back(mk_gnt(c0 + 1,  0, 0, 32'h300, 0));
        q1.push_back(mk_rv (c0 + 3,  0, 32'hFFFF_FCFF, 0));
        q1.push_back(mk_gnt(c0 + 4,  0, 0, 32'h300, 0));
        q1.push_back(mk_rv (c0 + 6,  0, 32'hFFFF_FCFF, 0));
        q1.push_back(mk_gnt(c0 + 7,  0, 0, 32'h300, 0));
        q1.push_back(mk_rv (c0 + 9,  0, 32'hFFFF_FCFF, 0));
        q1.push_back(mk_gnt(c0 + 10, 1, 0, 32'h400, 0));
        q1.push_back(mk_rv (c0 + 12, 1, 32'hFFFF_FBFF, 0));
        tick(8); p_m0_req = 0;
        tick(3); p_m1_req = 0;
        tick(3);

        // read timeout on m1, then a stray late response
        rsp_en = 0;
        c0 = cyc;
        m1_addr = 32'h40; m1_we = 0; m1_req = 1;
        q0.push_back(mk_gnt(c0 + 1, 1, 0, 32'h40, 0));
        q0.push_back(mk_rv (c0 + 6, 1, 32'hDEAD_BEEF, 1));
        tick(2); m1_req = 0;
        tick(5); inj_dat = 32'h0BAD_F00D; inj_vld = 1;
        tick(1); inj_vld = 0;
        tick(2);
        chk32("late_rsp_m1_rdata", m1_rdata, 32'hDEAD_BEEF);

        // reset while waiting for a read
        c0 = cyc;
        m0_addr = 32'h50; m0_we = 0; m0_req = 1;
        q0.push_back(mk_gnt(c0 + 1, 0, 0, 32'h50, 0));
        tick(2); m0_req = 0;
        tick(1);
        reset = 1;
        #1;
        chk_all_zero("reset_in_wait");
        tick(1); reset = 0; rsp_en = 1;

        // reset during a write ISSUE cycle
        tick(1);
        m0_addr = 32'h90; m0_wdata = 32'h55AA_55AA; m0_we = 1; m0_req = 1;
        tick(1);
        chk32("issue_ram_we_before_reset", 32'(ram_we), 32'h1);
        #1 reset = 1;
        #1;
        chk32("issue_ram_we_after_reset", 32'(ram_we), 32'h0);
        chk32("issue_gnt_after_reset",    32'(m0_gnt), 32'h0);
        m0_req = 0; m0_we = 0;
        tick(1); reset = 0;
        tick(1);

        // after reset m0 wins the first tie
        c0 = cyc;
        m0_addr = 32'h60; m1_addr = 32'h70; m0_req = 1; m1_req = 1;
        q0.push_back(mk_gnt(c0 + 1, 0, 0, 32'h60, 0));
        q0.push_back(mk_rv (c0 + 3, 0, 32'hFFFF_FF9F, 0));
        q0.push_back(mk_gnt(c0 + 4, 1, 0, 32'h70, 0));
        q0.push_back(mk_rv (c0 + 6, 1, 32'hFFFF_FF8F, 0));
        tick(2); m0_req = 0;
        tick(3); m1_req = 0;
        tick(3);

        // streaming writes from m0
        c0 = cyc;
        m0_addr = 32'h80; m0_wdata = 32'h1111_0000; m0_we = 1; m0_req = 1;
        q0.push_back(mk_gnt(c0 + 1, 0, 1, 32'h80, 32'h1111_0000));
        q0.push_back(mk_gnt(c0 + 3, 0, 1, 32'h80, 32'h2222_0000));
        q0.push_back(mk_gnt(c0 + 5, 0, 1, 32'h80, 32'h3333_0000));
        tick(2); m0_wdata = 32'h2222_0000;
        tick(2); m0_wdata = 32'h3333_0000;
        tick(2); m0_req = 0; m0_we = 0;
        tick(3);

        chk32("dut0_expected_events_left", 32'(q0.size()), 32'h0);
        chk32("dut1_expected_events_left", 32'(q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port synchronous data RAM between the DLX data port (master 0) and a second bus master (master 1, e.g. a video frame reader or DMA engine). It serialises accesses, drives the RAM address/write port from the winning master, and routes the RAM's delayed read data and valid strobe back to the owner. It also enforces a read timeout so that a missing `rdata_valid` never hangs a master.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum cycles spent in WAIT before a read is aborted (range 1..255).
- `M0_PRIORITY`, 0: 0 = round-robin between masters; 1 = master 0 always wins a tie.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` in 1: access request, held until `mN_gnt`.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in 32: byte address, passed through unchanged.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_gnt`, `m1_gnt` out 1: one-cycle pulse marking that the request was accepted.
- `m0_rdata`, `m1_rdata` out 32: read data, valid while `mN_rvalid` is high.
- `m0_rvalid`, `m1_rvalid` out 1: one-cycle read-completion pulse.
- `m0_err`, `m1_err` out 1: one-cycle pulse together with `rvalid` when a read timed out.
- `ram_addr` out 32, `ram_we` out 1, `ram_wdata` out 32: RAM command, all registered.
- `ram_rdata` in 32, `ram_rdata_valid` in 1: RAM response, arriving 1 cycle after the command.

## Operation
- FSM states are IDLE, ISSUE and WAIT. State `owner` (1 bit) records the granted master; `last` (1 bit) records the last master served.
- **IDLE:** `mN_req` is sampled only in IDLE.
  - Only one master is requesting: that master wins.
  - Both are requesting and `M0_PRIORITY`=1: master 0 wins.
  - Both are requesting and `M0_PRIORITY`=0: the master that is not `last` wins.
  - On the next edge: register `ram_addr`/`ram_wdata`/`ram_we` from the winner, set `owner` and `last`, assert the winner's `gnt`, and go to ISSUE.
- **ISSUE** (exactly 1 cycle): the RAM samples the command. `gnt` is high for this cycle only.
  - Write: go to IDLE.
  - Read: clear the timeout counter and go to WAIT.
- **WAIT:**
  - `ram_rdata_valid` high: register `ram_rdata` into the owner's `rdata`, pulse the owner's `rvalid`, go to IDLE.
  - Otherwise the counter increments. When it reaches `TIMEOUT`: load `rdata`=32'hDEADBEEF, pulse `rvalid` and `err`, go to IDLE.
- `ram_we` is 0 in every cycle except a write ISSUE.
- `ram_addr`/`ram_wdata` hold their last value outside ISSUE.
- `ram_rdata_valid` is ignored in IDLE and ISSUE (a late response after a timeout is discarded).
- The non-owner's `gnt`/`rvalid`/`err` stay 0. Its `rdata` holds its previous value.
- A master holding `req` high after `gnt` is treated as a new request at the next IDLE (streaming). Masters drop `req` the cycle after seeing `gnt` for single accesses.

## Timing
- Reset (asynchronous): state=IDLE, `last`=1 (master 0 wins the first tie), `owner`=0, counter=0. Every output is 0, including `ram_*` and all `rdata`.
- Read, with the request seen in IDLE at cycle 0:
  - `gnt` and the RAM command in cycle 1.
  - `ram_rdata_valid` in cycle 2.
  - `rvalid`/`rdata` in cycle 3; IDLE again in cycle 3.
  - Result: 3-cycle latency, next grant no earlier than cycle 4.
- Write, with the request seen at cycle 0:
  - `gnt` and `ram_we` in cycle 1; IDLE in cycle 2.
  - Result: minimum 2 cycles per write.
- Timeout read: `rvalid`+`err` in cycle 2+`TIMEOUT`.
- Round-robin under continuous contention strictly alternates masters.
- `reset` asserted in ISSUE or WAIT:
  - The access is dropped, with no `rvalid`.
  - If asserted in ISSUE, `ram_we` falls immediately.

## Test plan
- **Single read:** after reset, m0 reads addr 0x10 and the RAM returns 0x12345678 → `m0_gnt` in cycle 1, `ram_addr`=0x10 with `ram_we`=0 in cycle 1, `m0_rvalid` with `m0_rdata`=0x12345678 in cycle 3; m1 outputs stay 0.
- **Single write:** m1 writes 0xCAFEF00D to 0x20 → `ram_we`=1 for exactly cycle 1 with matching addr/wdata; `m1_gnt` pulses once; no `rvalid`.
- **Contention:** both masters hold read requests for 4 accesses with `M0_PRIORITY`=0 → grants go m0, m1, m0, m1. Repeat with `M0_PRIORITY`=1 → all grants go to m0 while m0 keeps requesting.
- **Timeout:** with `TIMEOUT`=4, an m1 read gets no `ram_rdata_valid` → at cycle 6 `m1_rvalid`=`m1_err`=1 with `m1_rdata`=0xDEADBEEF. A `ram_rdata_valid` injected at cycle 7 changes nothing.
- **Reset mid-read:** assert `reset` in WAIT → all outputs are 0 at once; after release, m0 wins a tie with m1.
- **Streaming:** m0 holds `req`=1 with `we`=1 for 3 writes → `m0_gnt` in cycles 1, 3 and 5; `ram_we` is never high in consecutive cycles.
